// File: rtl/score_tracker_if.sv
// -----------------------------------------------------------------------------
// score_tracker_if
//   Bundles the game event strobes coming from the player controller and the
//   score outputs that go to the display/render, sound and speed-up stages.
//
//   Signals
//     game_tick         [1:0]         tick strobes (only bit 0 is meaningful)
//     game_start_pulse                one-cycle strobe, new run begins
//     game_over_pulse                 one-cycle strobe, run ended by crash
//     score             [4*DIGITS-1:0] current BCD score, digit 0 in [3:0]
//     high_score        [4*DIGITS-1:0] best BCD score since reset
//     new_high                        last finished run set a new high score
//     milestone_pulse                 one-cycle strobe at each nonzero x100
//     counting                        tracker is in its counting state
//
//   Modports
//     master : event producer / score consumer (controller side, testbench)
//     slave  : the score tracker itself
// -----------------------------------------------------------------------------
interface score_tracker_if #(
  parameter int DIGITS = 4
);

  logic [1:0]          game_tick;
  logic                game_start_pulse;
  logic                game_over_pulse;
  logic [4*DIGITS-1:0] score;
  logic [4*DIGITS-1:0] high_score;
  logic                new_high;
  logic                milestone_pulse;
  logic                counting;

  modport master (
    output game_tick,
    output game_start_pulse,
    output game_over_pulse,
    input  score,
    input  high_score,
    input  new_high,
    input  milestone_pulse,
    input  counting
  );

  modport slave (
    input  game_tick,
    input  game_start_pulse,
    input  game_over_pulse,
    output score,
    output high_score,
    output new_high,
    output milestone_pulse,
    output counting
  );

endinterface

// File: rtl/score_tracker.sv
// -----------------------------------------------------------------------------
// score_tracker
//   Keeps a BCD running score for the current run and a session high score.
//   Every TICKS_PER_POINT pulses on game_tick[0] add one point. The score
//   saturates at all-nines. A one-cycle milestone pulse marks each nonzero
//   multiple of 100. At the end of a run the score is compared against the
//   high score, and new_high reports whether the run beat it.
//
//   Parameters
//     DIGITS          number of BCD digits in score/high_score (3..6)
//     TICKS_PER_POINT game_tick[0] pulses per point (1..255)
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset, clears everything incl. high score
//     bus    score_tracker_if.slave: event strobes in, score outputs out
//
//   All outputs come straight from flops; no input reaches an output
//   combinationally.
// -----------------------------------------------------------------------------
module score_tracker #(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  score_tracker_if.slave bus
);

  localparam int W  = 4 * DIGITS;
  // 8 bits covers the whole legal TICKS_PER_POINT range.
  localparam int PW = 8;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_POINT - 1);
  localparam logic [W-1:0]  ALL_NINES  = {DIGITS{4'd9}};
  localparam logic [W-1:0]  ZERO_SCORE = {W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_FROZEN   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------------

  // Ripple increment: each digit at 9 wraps to 0 and passes the carry upward.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (v[4*d +: 4] == 4'd9) begin
          r[4*d +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[4*d +: 4] = v[4*d +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[4*d +: 4] = v[4*d +: 4];
      end
    end
    return r;
  endfunction

  // Magnitude compare scanning from the most significant digit down; the
  // first differing digit decides.
  function automatic logic bcd_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (!decided && (a[4*d +: 4] != b[4*d +: 4])) begin
        gt      = (a[4*d +: 4] > b[4*d +: 4]);
        decided = 1'b1;
      end else begin
        gt      = gt;
        decided = decided;
      end
    end
    return gt;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t          state_r;
  state_t          state_nxt_s;
  logic [W-1:0]    score_r;
  logic [W-1:0]    score_nxt_s;
  logic [W-1:0]    high_r;
  logic [W-1:0]    high_nxt_s;
  logic [PW-1:0]   presc_r;
  logic [PW-1:0]   presc_nxt_s;
  logic            new_high_r;
  logic            new_high_nxt_s;
  logic            milestone_r;
  logic            milestone_nxt_s;
  logic            counting_r;
  logic            counting_nxt_s;

  logic            tick_s;
  logic            start_s;
  logic            over_s;
  logic [W-1:0]    score_inc_s;
  logic            saturated_s;
  logic            score_beats_high_s;

  // game_tick[1] belongs to other consumers of the shared tick bus.
  assign tick_s             = bus.game_tick[0];
  assign start_s            = bus.game_start_pulse;
  assign over_s             = bus.game_over_pulse;
  assign score_inc_s        = bcd_inc(score_r);
  assign saturated_s        = (score_r == ALL_NINES);
  assign score_beats_high_s = bcd_gt(score_r, high_r);

  // Next-state and next-output logic for the run FSM.
  always_comb begin
    state_nxt_s     = state_r;
    score_nxt_s     = score_r;
    high_nxt_s      = high_r;
    presc_nxt_s     = presc_r;
    new_high_nxt_s  = new_high_r;
    milestone_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE, ST_FROZEN: begin
        // Only a start leaves these states; game over is meaningless here.
        if (start_s) begin
          state_nxt_s    = ST_COUNTING;
          score_nxt_s    = ZERO_SCORE;
          presc_nxt_s    = {PW{1'b0}};
          new_high_nxt_s = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end

      ST_COUNTING: begin
        if (over_s) begin
          // The pre-increment score is final; a coincident tick is dropped.
          state_nxt_s = ST_FROZEN;
          if (score_beats_high_s) begin
            high_nxt_s     = score_r;
            new_high_nxt_s = 1'b1;
          end else begin
            new_high_nxt_s = 1'b0;
          end
        end else if (start_s) begin
          // Restart without ending the run: new_high keeps the last result.
          score_nxt_s = ZERO_SCORE;
          presc_nxt_s = {PW{1'b0}};
        end else if (tick_s) begin
          if (presc_r == PRESC_LAST) begin
            presc_nxt_s = {PW{1'b0}};
            // At all-nines the score holds but the prescaler keeps cycling.
            if (!saturated_s) begin
              score_nxt_s     = score_inc_s;
              milestone_nxt_s = (score_inc_s[7:0] == 8'h00) &&
                                (score_inc_s != ZERO_SCORE);
            end else begin
              score_nxt_s = score_r;
            end
          end else begin
            presc_nxt_s = presc_r + 8'd1;
          end
        end else begin
          state_nxt_s = ST_COUNTING;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a safe idle with a cleared run.
        state_nxt_s    = ST_IDLE;
        score_nxt_s    = ZERO_SCORE;
        presc_nxt_s    = {PW{1'b0}};
        new_high_nxt_s = 1'b0;
      end
    endcase

    counting_nxt_s = (state_nxt_s == ST_COUNTING);
  end

  // State, score and output flops with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      score_r     <= ZERO_SCORE;
      high_r      <= ZERO_SCORE;
      presc_r     <= {PW{1'b0}};
      new_high_r  <= 1'b0;
      milestone_r <= 1'b0;
      counting_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      score_r     <= score_nxt_s;
      high_r      <= high_nxt_s;
      presc_r     <= presc_nxt_s;
      new_high_r  <= new_high_nxt_s;
      milestone_r <= milestone_nxt_s;
      counting_r  <= counting_nxt_s;
    end
  end

  assign bus.score           = score_r;
  assign bus.high_score      = high_r;
  assign bus.new_high        = new_high_r;
  assign bus.milestone_pulse = milestone_r;
  assign bus.counting        = counting_r;

endmodule
